// File: rtl/skew_input_buffer_pkg.sv
// Shared definitions for the skew input buffer.
// Contents: FSM state encodings, a constant-evaluable clog2 and a lane-slice helper that
// gives the LSB position of lane k inside a packed multi-lane vector.
package skew_input_buffer_pkg;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;

  // Ceiling log2; usable in parameter expressions.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((64'd1 << result) < 64'(value)) begin
      result = result + 1;
    end
    return result;
  endfunction

  // LSB of lane `lane` in a vector packed as {lane[N-1], ..., lane[0]}.
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/skew_lane.sv
// One lane of the skew buffer: a data+valid delay line stepped by `advance`, with two
// compile-time taps (forward / reverse) picked at run time by `reverse`.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   advance      global step enable; everything holds when low
//   push_valid   element pushed this step is real (else a zero bubble is pushed)
//   push_data    element data
//   reverse      selects REV_TAP instead of FWD_TAP
//   out_data     registered tap data, forced to zero when out_valid is low
//   out_valid    registered tap valid
module skew_lane
  import skew_input_buffer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned FWD_TAP    = 0,
  parameter int unsigned REV_TAP    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  advance,
  input  logic                  push_valid,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  reverse,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid
);

  // Entries beyond the deeper of the two taps can never reach the output, so the line
  // only stores up to that point (capped at DEPTH).
  localparam int unsigned MaxTap    = (FWD_TAP > REV_TAP) ? FWD_TAP : REV_TAP;
  localparam int unsigned LineDepth = (MaxTap < DEPTH) ? MaxTap + 1 : DEPTH;

  // Entry 0 holds the most recently pushed element.
  logic [LineDepth*DATA_WIDTH-1:0] line_q;
  logic [LineDepth-1:0]            valid_q;
  logic [DATA_WIDTH-1:0]           tap_data;
  logic                            tap_valid;

  always_comb begin
    tap_data  = reverse ? line_q[REV_TAP*DATA_WIDTH +: DATA_WIDTH]
                        : line_q[FWD_TAP*DATA_WIDTH +: DATA_WIDTH];
    tap_valid = reverse ? valid_q[REV_TAP] : valid_q[FWD_TAP];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      line_q    <= '0;
      valid_q   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (advance) begin
      line_q    <= {line_q[(LineDepth-1)*DATA_WIDTH-1:0],
                    (push_valid ? push_data : {DATA_WIDTH{1'b0}})};
      valid_q   <= {valid_q[LineDepth-2:0], push_valid};
      out_data  <= tap_valid ? tap_data : '0;
      out_valid <= tap_valid;
    end
  end

endmodule

// File: rtl/skew_input_buffer.sv
// Handshaked triangular skew buffer feeding one edge of a ROWS x ROWS PE array.
// Lane k of each accepted vector is delayed k steps (ROWS-1-k when reversed).
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   cfg_reverse      skew direction, latched only while idle
//   in_valid/ready   input vector handshake; in_data packs lane k at [DW*(k+1)-1 -: DW]
//   flush            drain request
//   out_ready        global step enable from the PE array
//   out_data         skewed lanes, zero where the lane is not valid
//   out_lane_valid   per-lane element valid
//   busy             not idle
//   done             one-cycle drain-complete pulse
module skew_input_buffer
  import skew_input_buffer_pkg::*;
#(
  parameter int unsigned ROWS       = 4,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_reverse,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ROWS*DATA_WIDTH-1:0] in_data,
  input  logic                       flush,
  input  logic                       out_ready,
  output logic [ROWS*DATA_WIDTH-1:0] out_data,
  output logic [ROWS-1:0]            out_lane_valid,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned CntWidth = clog2(ROWS + 1);

  logic [1:0]          state_q;
  logic [CntWidth-1:0] drain_cnt_q;
  logic                reverse_q;
  logic                done_q;
  logic                advance;
  logic                accept;

  assign advance  = out_ready;
  assign in_ready = out_ready && (state_q != StDrain);
  assign accept   = in_valid && in_ready;
  assign busy     = (state_q != StIdle);
  assign done     = done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      drain_cnt_q <= '0;
      reverse_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      // done is a pulse; it does not wait for advance.
      done_q <= 1'b0;
      if (state_q == StIdle) begin
        reverse_q <= cfg_reverse;
      end
      case (state_q)
        StIdle: begin
          if (flush && accept) begin
            drain_cnt_q <= CntWidth'(ROWS);
            state_q     <= StDrain;
          end else if (flush) begin
            done_q <= 1'b1;
          end else if (accept) begin
            state_q <= StRun;
          end
        end
        StRun: begin
          // A vector accepted on this edge is already in the lines, so a full ROWS-step
          // drain covers it.
          if (flush) begin
            drain_cnt_q <= CntWidth'(ROWS);
            state_q     <= StDrain;
          end
        end
        StDrain: begin
          if (advance) begin
            drain_cnt_q <= drain_cnt_q - 1'b1;
            if (drain_cnt_q == CntWidth'(1)) begin
              done_q  <= 1'b1;
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  for (genvar k = 0; k < ROWS; k++) begin : g_lane
    skew_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (ROWS),
      .FWD_TAP    (k),
      .REV_TAP    (ROWS - 1 - k)
    ) u_lane (
      .clk        (clk),
      .rst        (rst),
      .advance    (advance),
      .push_valid (accept),
      .push_data  (in_data[lane_lsb(k, DATA_WIDTH) +: DATA_WIDTH]),
      .reverse    (reverse_q),
      .out_data   (out_data[lane_lsb(k, DATA_WIDTH) +: DATA_WIDTH]),
      .out_valid  (out_lane_valid[k])
    );
  end

endmodule
